// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU MAC datapath and its sequencer.
package npu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned K_MAX  = 511;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      ISSUE,
      CALC,
      OUT,
      DONE
   } seq_state_t;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Running operand-buffer address: loads the job base, then steps once per read.
module pe_seq_addr_gen
   import npu_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr
);

   // Tiles are contiguous in the buffer, so a single incrementing pointer
   // yields base + tile*k_len + k without a multiplier; wrap is intentional.
   always_ff @(posedge clk) begin
      if (!rst_n)
         addr <= '0;
      else if (load)
         addr <= base;
      else if (inc)
         addr <= addr + ADDR_W'(1);
   end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Drives a shared-control PE array through num_tiles dot products of length k_len,
// handing each tile result out over a valid/ready handshake.
module pe_mac_sequencer
   import npu_pkg::*;
#(
   parameter int unsigned K_W    = 9,
   parameter int unsigned TILE_W = 8,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [K_W-1:0]    k_len,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              buf_rd_en,
   output logic [ADDR_W-1:0] buf_rd_addr,
   output logic              pe_ready,
   output logic              pe_clr_n,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [TILE_W-1:0] res_idx
);

   seq_state_t        state, state_nx;
   logic [K_W-1:0]    k, k_len_q;
   logic [TILE_W-1:0] tile, num_tiles_q;
   logic              accept, k_last, tile_last;

   assign accept    = (state == IDLE) && start;
   // Only evaluated in CALC/OUT, where the latched counts are at least 1.
   assign k_last    = (k + K_W'(1)) >= k_len_q;
   assign tile_last = (tile + TILE_W'(1)) == num_tiles_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         k           <= '0;
         tile        <= '0;
         k_len_q     <= '0;
         num_tiles_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  k_len_q     <= k_len;
                  num_tiles_q <= num_tiles;
                  tile        <= '0;
                  k           <= '0;
               end
            end
            CLEAR: k <= '0;
            CALC: begin
               if (!k_last)
                  k <= k + K_W'(1);
            end
            OUT: begin
               if (res_ready && !tile_last)
                  tile <= tile + TILE_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      busy      = 1'b1;
      done      = 1'b0;
      buf_rd_en = 1'b0;
      pe_ready  = 1'b0;
      res_valid = 1'b0;
      res_idx   = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nx = (num_tiles == '0) ? DONE : CLEAR;
         end
         CLEAR: state_nx = (k_len_q == '0) ? OUT : FETCH;
         FETCH: begin
            buf_rd_en = 1'b1;
            state_nx  = ISSUE;
         end
         ISSUE: begin
            pe_ready = 1'b1;
            state_nx = CALC;
         end
         CALC: begin
            // The next read lands on the same edge the PE consumes the current pair.
            if (!k_last) begin
               buf_rd_en = 1'b1;
               state_nx  = ISSUE;
            end else begin
               state_nx = OUT;
            end
         end
         OUT: begin
            res_valid = 1'b1;
            res_idx   = tile;
            if (res_ready)
               state_nx = tile_last ? DONE : CLEAR;
         end
         DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   assign pe_clr_n = rst_n & (state != CLEAR);

   pe_seq_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .base  (base_addr),
      .inc   (buf_rd_en),
      .addr  (buf_rd_addr)
   );

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench: sequencer driving a behavioural 2x2 PE array and 1-cycle-latency operand RAM.
module tb_pe_mac_sequencer;
   import npu_pkg::*;

   localparam int unsigned K_W    = 9;
   localparam int unsigned TILE_W = 8;
   localparam int unsigned ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [K_W-1:0]    k_len = '0;
   logic [TILE_W-1:0] num_tiles = '0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              busy, done, buf_rd_en, pe_ready, pe_clr_n, res_valid;
   logic              res_ready = 1'b0;
   logic [ADDR_W-1:0] buf_rd_addr;
   logic [TILE_W-1:0] res_idx;

   always #5 clk = ~clk;

   pe_mac_sequencer #(
      .K_W    (K_W),
      .TILE_W (TILE_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .k_len       (k_len),
      .num_tiles   (num_tiles),
      .base_addr   (base_addr),
      .busy        (busy),
      .done        (done),
      .buf_rd_en   (buf_rd_en),
      .buf_rd_addr (buf_rd_addr),
      .pe_ready    (pe_ready),
      .pe_clr_n    (pe_clr_n),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_idx     (res_idx)
   );

   function automatic logic signed [23:0] mul(input logic signed [7:0] a, input logic signed [7:0] b);
      logic signed [15:0] p;
      p = a * b;
      return {{8{p[15]}}, p};
   endfunction

   // Operand RAM: lane i of A feeds PE row i, lane j of B feeds PE column j.
   logic signed [7:0]  mem_a [0:1][0:65535];
   logic signed [7:0]  mem_b [0:1][0:65535];
   logic signed [7:0]  rd_a [0:1];
   logic signed [7:0]  rd_b [0:1];
   logic               pe_calc;
   logic signed [23:0] acc [0:1][0:1];

   always @(posedge clk) begin
      if (buf_rd_en) begin
         for (int i = 0; i < 2; i++) begin
            rd_a[i] <= mem_a[i][buf_rd_addr];
            rd_b[i] <= mem_b[i][buf_rd_addr];
         end
      end
   end

   always @(posedge clk) begin
      if (!pe_clr_n) begin
         pe_calc <= 1'b0;
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
               acc[i][j] <= '0;
      end else begin
         pe_calc <= pe_ready;
         if (pe_calc)
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 2; j++)
                  acc[i][j] <= acc[i][j] + mul(rd_a[i], rd_b[j]);
      end
   end

   typedef struct packed {
      logic [7:0]       idx;
      logic [3:0][23:0] sum;
   } exp_t;

   exp_t              exp_q[$];
   logic [15:0]       rd_q[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                first_valid, done_cyc, n_pe_rdy, viol;
   logic signed [23:0] last_acc00;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_expected(input int kl, input int nt, input logic [15:0] base);
      exp_t        e;
      logic [15:0] a;
      for (int t = 0; t < nt; t++) begin
         e.idx = 8'(t);
         e.sum = '0;
         for (int k = 0; k < kl; k++) begin
            a = base + 16'(t * kl + k);
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 2; j++)
                  e.sum[i*2+j] = e.sum[i*2+j] + mul(mem_a[i][a], mem_b[j][a]);
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic run_job(input int kl, input int nt, input logic [15:0] base,
                          input int hold, input bit disturb, input int abort_cyc);
      int          wait_c;
      bit          fin, prev_rdy, prev_valid;
      logic [7:0]  prev_idx;
      exp_t        e;
      push_expected(kl, nt, base);
      first_valid = -1;
      done_cyc    = -1;
      n_pe_rdy    = 0;
      viol        = 0;
      rd_q.delete();
      @(negedge clk);
      k_len = K_W'(kl); num_tiles = TILE_W'(nt); base_addr = base;
      start = 1'b1; res_ready = 1'b0;
      wait_c = 0; fin = 0; prev_rdy = 0; prev_valid = 0; prev_idx = '0;
      for (int c = 1; c <= 5000 && !fin; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == abort_cyc) begin
            rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
            return;
         end
         if (pe_ready && prev_rdy) viol++;
         if (pe_ready && !pe_clr_n) viol++;
         if (!busy && !done) viol++;
         prev_rdy = pe_ready;
         if (pe_ready) n_pe_rdy++;
         if (buf_rd_en) rd_q.push_back(buf_rd_addr);
         if (res_valid) begin
            if (first_valid < 0) first_valid = c;
            if (prev_valid && res_idx !== prev_idx) viol++;
            res_ready = (wait_c >= hold);
            wait_c++;
            if (res_ready) begin
               if (exp_q.size() == 0) begin
                  check("sb_underflow", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("res_idx", res_idx, e.idx);
                  for (int p = 0; p < 4; p++)
                     check($sformatf("pe%0d%0d_sum", p / 2, p % 2), acc[p/2][p%2], $signed(e.sum[p]));
                  last_acc00 = acc[0][0];
               end
               wait_c = 0; prev_valid = 0;
            end else begin
               prev_valid = 1; prev_idx = res_idx;
            end
         end else begin
            res_ready  = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_valid = 0;
         end
         if (done) begin
            if (busy) viol++;
            done_cyc = c; fin = 1;
            start = 1'b0; res_ready = 1'b0;
         end else if (disturb) begin
            start     = 1'($urandom_range(0, 1));
            k_len     = K_W'($urandom);
            num_tiles = TILE_W'($urandom);
            base_addr = ADDR_W'($urandom);
         end else if (c == 1) begin
            start = 1'b0;
         end
      end
      if (!fin) check("done_timeout", 0, 1);
      check("sb_drained", exp_q.size(), 0);
      check("protocol", viol, 0);
   endtask

   initial begin
      int seen_done;
      for (int a = 0; a < 65536; a++)
         for (int i = 0; i < 2; i++) begin
            mem_a[i][a] = 8'($urandom);
            mem_b[i][a] = 8'($urandom);
         end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", buf_rd_en, 0);
      check("rst_rd_addr", buf_rd_addr, 0);
      check("rst_pe_ready", pe_ready, 0);
      check("rst_pe_clr_n", pe_clr_n, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_idx", res_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_pe_clr_n", pe_clr_n, 1);

      // 1) basic dot product A={1,2,3} . B={4,5,6}
      mem_a[0][0] = 8'sd1; mem_a[0][1] = 8'sd2; mem_a[0][2] = 8'sd3;
      mem_b[0][0] = 8'sd4; mem_b[0][1] = 8'sd5; mem_b[0][2] = 8'sd6;
      run_job(3, 1, 16'h0000, 0, 0, -1);
      check("t1_first_valid", first_valid, 9);
      check("t1_done_cyc", done_cyc, 10);
      check("t1_pe00", last_acc00, 32);

      // 2) three tiles, consumer stalls, each address read once
      run_job(2, 3, 16'h0000, 5, 0, -1);
      check("t2_first_valid", first_valid, 7);
      check("t2_rd_count", rd_q.size(), 6);
      for (int i = 0; i < 6 && i < rd_q.size(); i++)
         check($sformatf("t2_rd_addr%0d", i), rd_q[i], i);

      // 3) longest tile at the most negative operand
      for (int a = 16'h1000; a < 16'h1000 + 511; a++)
         for (int i = 0; i < 2; i++) begin
            mem_a[i][a] = -8'sd128;
            mem_b[i][a] = -8'sd128;
         end
      run_job(511, 1, 16'h1000, 0, 0, -1);
      check("t3_pe00", last_acc00, 8372224);
      check("t3_pe_ready_pulses", n_pe_rdy, 511);
      check("t3_first_valid", first_valid, 1025);

      // 4) empty tile and empty job
      run_job(0, 1, 16'h0000, 0, 0, -1);
      check("t4_first_valid", first_valid, 2);
      check("t4_pe00", last_acc00, 0);
      check("t4_no_reads", rd_q.size(), 0);
      run_job(5, 0, 16'h0000, 0, 0, -1);
      check("t4_empty_done_cyc", done_cyc, 1);
      check("t4_empty_no_valid", first_valid, -1);

      // 5) reset during CALC of tile 1 (cycle 13), then restart
      run_job(3, 2, 16'h0040, 0, 0, 13);
      @(negedge clk);
      check("t5_busy", busy, 0);
      check("t5_rd_en", buf_rd_en, 0);
      check("t5_pe_ready", pe_ready, 0);
      check("t5_res_valid", res_valid, 0);
      check("t5_rd_addr", buf_rd_addr, 0);
      check("t5_pe_clr_n", pe_clr_n, 0);
      check("t5_acc00", acc[0][0], 0);
      check("t5_acc11", acc[1][1], 0);
      rst_n = 1'b1;
      exp_q.delete();
      seen_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      check("t5_no_done", seen_done, 0);
      run_job(3, 1, 16'h0000, 0, 0, -1);
      check("t5_restart_first_valid", first_valid, 9);
      check("t5_restart_pe00", last_acc00, 32);

      // 6) inputs and start churn mid-job; address wrap
      run_job(4, 2, 16'hFFFE, 2, 1, -1);
      check("t6_first_valid", first_valid, 11);
      check("t6_rd_count", rd_q.size(), 8);
      for (int i = 0; i < 8 && i < rd_q.size(); i++)
         check($sformatf("t6_rd_addr%0d", i), rd_q[i], 16'(16'hFFFE + i));
      @(negedge clk);
      check("t6_idle_after", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
